// File: rtl/l1_line_fill_responder.sv
// L1 line-fill responder.
// Accepts one line-fill request at a time and reads the line's words from
// backing memory, one word per cycle. It then holds the assembled line until
// the L1 takes it. A thread-kill flush that matches the owning thread
// abandons the transaction.
module l1_line_fill_responder #(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int TID_BITS   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [WIDTH-1:0]            req_addr,
    input  logic [TID_BITS-1:0]         req_tid,
    output logic                        mem_rd_en,
    output logic [WIDTH-1:0]            mem_addr,
    input  logic [WIDTH-1:0]            mem_rdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH*BLOCK_SIZE-1:0] rsp_line,
    output logic [TID_BITS-1:0]         rsp_tid,
    input  logic                        flush_valid,
    input  logic [TID_BITS-1:0]         flush_tid,
    output logic                        busy
);

    localparam int KW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [KW-1:0]               k_q;
    logic [WIDTH-1:0]            base_q;
    logic [WIDTH-1:0]            mem_addr_q;
    logic [TID_BITS-1:0]         tid_q;
    logic [WIDTH*BLOCK_SIZE-1:0] line_q;

    logic          accept;
    logic          flush_hit;
    logic          k_last;
    logic          wr_en;
    logic [KW-1:0] wr_idx;

    // The low nibble of the request address selects a byte within the line
    // and plays no part in the fill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[3:0];

    assign accept    = req_valid && req_ready;
    assign flush_hit = flush_valid && (flush_tid == tid_q);
    assign k_last    = (k_q == KW'(BLOCK_SIZE - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state elements use non-blocking assignments so every register
        // samples pre-edge values, whatever order the blocks are evaluated in.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: a matching flush abandons FETCH/LAST, and in RESP it
    // drops the line unless the handshake completes that same cycle.
    always_comb begin
        // NOTE: default first so that no path through the case leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept)                  state_d = FETCH;
            FETCH: if (flush_hit)               state_d = IDLE;
                   else if (k_last)             state_d = LAST;
            LAST:  state_d = flush_hit ? IDLE : RESP;
            RESP:  if (rsp_ready || flush_hit)  state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Output decode from registered state. While reset is asserted the state
    // is already IDLE, so ready is gated by rst_n to stay low until release.
    always_comb begin
        req_ready = (state_q == IDLE) && rst_n;
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == RESP);
        mem_rd_en = (state_q == FETCH) && !flush_hit;
        mem_addr  = mem_rd_en ? (base_q + (WIDTH'(k_q) << 2)) : mem_addr_q;
        wr_en     = ((state_q == FETCH) && (k_q != '0)) || (state_q == LAST);
        wr_idx    = (state_q == LAST) ? KW'(BLOCK_SIZE - 1) : (k_q - 1'b1);
    end

    // Transaction registers: base/tid latch on accept, beat counter advances
    // in FETCH, and read data lands one beat behind its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            base_q     <= '0;
            tid_q      <= '0;
            mem_addr_q <= '0;
            // NOTE: the line buffer is a plain register, not a RAM, and it
            // drives rsp_line directly, so it is cleared like any other output.
            line_q     <= '0;
        end else begin
            if (accept) begin
                base_q <= {req_addr[WIDTH-1:4], 4'b0000};
                tid_q  <= req_tid;
                k_q    <= '0;
            end else if (state_q == FETCH) begin
                k_q <= k_last ? '0 : k_q + 1'b1;
            end

            if (mem_rd_en) begin
                mem_addr_q <= mem_addr;
            end

            if (wr_en) begin
                line_q[wr_idx*WIDTH +: WIDTH] <= mem_rdata;
            end
        end
    end

    assign rsp_line = line_q;
    assign rsp_tid  = tid_q;

endmodule

// File: tb/tb_l1_line_fill_responder.sv
// Directed bench for the L1 line-fill responder. A backing-memory model
// returns (address ^ 0xC0DE_0000) one cycle after each read strobe. Expected
// addresses and lines are written out by hand.
module tb_l1_line_fill_responder;

    localparam int WIDTH      = 32;
    localparam int BLOCK_SIZE = 4;
    localparam int TID_BITS   = 2;
    localparam logic [31:0] KEY = 32'hC0DE_0000;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        req_valid;
    logic                        req_ready;
    logic [WIDTH-1:0]            req_addr;
    logic [TID_BITS-1:0]         req_tid;
    logic                        mem_rd_en;
    logic [WIDTH-1:0]            mem_addr;
    logic [WIDTH-1:0]            mem_rdata;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [WIDTH*BLOCK_SIZE-1:0] rsp_line;
    logic [TID_BITS-1:0]         rsp_tid;
    logic                        flush_valid;
    logic [TID_BITS-1:0]         flush_tid;
    logic                        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;

    l1_line_fill_responder #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BLOCK_SIZE), .TID_BITS(TID_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_tid(req_tid),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_line(rsp_line), .rsp_tid(rsp_tid),
        .flush_valid(flush_valid), .flush_tid(flush_tid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Backing memory: data valid exactly one cycle after the strobe.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    // Handshake counter.
    always @(posedge clk) begin
        if (rsp_valid && rsp_ready) hs_count <= hs_count + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and walk it to RESP, checking every beat.
    // fl_beat: -1 none, 0 flush in the accept cycle, b+1 flush during beat b.
    task automatic run_to_resp(input logic [31:0] addr, input logic [1:0] tid,
                               input logic [31:0] base, input int fl_beat,
                               input logic [1:0] fl_tid, input logic [127:0] exp_line);
        req_valid = 1'b1;
        req_addr  = addr;
        req_tid   = tid;
        if (fl_beat == 0) begin
            flush_valid = 1'b1;
            flush_tid   = fl_tid;
        end
        #1;
        check("accept_ready", req_ready, 1'b1);
        tick();
        req_valid   = 1'b0;
        flush_valid = 1'b0;
        for (int b = 0; b < BLOCK_SIZE; b++) begin
            if (fl_beat == b + 1) begin
                flush_valid = 1'b1;
                flush_tid   = fl_tid;
            end
            #1;
            check("fetch_rd_en", mem_rd_en, 1'b1);
            check("fetch_addr", mem_addr, base + 32'(4 * b));
            check("fetch_ready_low", req_ready, 1'b0);
            tick();
            flush_valid = 1'b0;
        end
        check("last_rd_en", mem_rd_en, 1'b0);
        check("last_addr_hold", mem_addr, base + 32'd12);
        check("last_no_rsp", rsp_valid, 1'b0);
        tick();
        check("resp_valid", rsp_valid, 1'b1);
        check("resp_line", rsp_line, exp_line);
        check("resp_tid", rsp_tid, tid);
        check("resp_busy", busy, 1'b1);
    endtask

    task automatic finish_resp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_rsp_ready", req_ready, 1'b1);
    endtask

    initial begin
        int hs0;
        logic saw;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_tid     = '0;
        rsp_ready   = 1'b0;
        flush_valid = 1'b0;
        flush_tid   = '0;

        // Reset values before any clock edge.
        #3;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_line", rsp_line, 128'h0);
        check("rst_rsp_tid", rsp_tid, 2'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 1'b1);
        tick();

        // Basic fill of 0x1238 for tid 2, then 5 back-pressure cycles.
        run_to_resp(32'h0000_1238, 2'd2, 32'h0000_1230, -1, 2'd0,
                    128'hC0DE123C_C0DE1238_C0DE1234_C0DE1230);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_line", rsp_line, 128'hC0DE123C_C0DE1238_C0DE1234_C0DE1230);
            check("hold_tid", rsp_tid, 2'd2);
            check("hold_ready_low", req_ready, 1'b0);
        end
        finish_resp();

        // Matching flush during FETCH beat k=2 of a tid-1 fill.
        req_valid = 1'b1;
        req_addr  = 32'h0000_2000;
        req_tid   = 2'd1;
        tick();
        req_valid = 1'b0;
        check("fl_k0_addr", mem_addr, 32'h0000_2000);
        tick();
        check("fl_k1_addr", mem_addr, 32'h0000_2004);
        tick();
        flush_valid = 1'b1;
        flush_tid   = 2'd1;
        #1;
        check("fl_rd_en_low", mem_rd_en, 1'b0);
        check("fl_addr_hold", mem_addr, 32'h0000_2004);
        tick();
        flush_valid = 1'b0;
        check("fl_idle_busy", busy, 1'b0);
        check("fl_idle_ready", req_ready, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            saw = saw | rsp_valid | mem_rd_en;
            tick();
        end
        check("fl_no_rsp", saw, 1'b0);
        run_to_resp(32'h0000_3004, 2'd1, 32'h0000_3000, -1, 2'd0,
                    128'hC0DE300C_C0DE3008_C0DE3004_C0DE3000);
        finish_resp();

        // Non-matching flush mid-fill, then a flush in IDLE with a same-cycle request.
        run_to_resp(32'h0000_4010, 2'd0, 32'h0000_4010, 2, 2'd3,
                    128'hC0DE401C_C0DE4018_C0DE4014_C0DE4010);
        finish_resp();
        run_to_resp(32'h0000_5000, 2'd0, 32'h0000_5000, 0, 2'd0,
                    128'hC0DE500C_C0DE5008_C0DE5004_C0DE5000);
        finish_resp();

        // Matching flush in RESP together with rsp_ready: delivered once.
        run_to_resp(32'h0000_6000, 2'd2, 32'h0000_6000, -1, 2'd0,
                    128'hC0DE600C_C0DE6008_C0DE6004_C0DE6000);
        hs0         = hs_count;
        rsp_ready   = 1'b1;
        flush_valid = 1'b1;
        flush_tid   = 2'd2;
        tick();
        rsp_ready   = 1'b0;
        flush_valid = 1'b0;
        check("flr_valid", rsp_valid, 1'b0);
        check("flr_ready", req_ready, 1'b1);
        check("flr_hs_once", 32'(hs_count - hs0), 32'd1);
        tick();
        check("flr_hs_still_once", 32'(hs_count - hs0), 32'd1);

        // Matching flush in RESP without rsp_ready: line dropped.
        run_to_resp(32'h0000_6104, 2'd3, 32'h0000_6100, -1, 2'd0,
                    128'hC0DE610C_C0DE6108_C0DE6104_C0DE6100);
        hs0         = hs_count;
        flush_valid = 1'b1;
        flush_tid   = 2'd3;
        tick();
        flush_valid = 1'b0;
        check("fln_valid", rsp_valid, 1'b0);
        check("fln_busy", busy, 1'b0);
        check("fln_hs_none", 32'(hs_count - hs0), 32'd0);

        // Reset pulsed at T+3 of an in-flight fill.
        req_valid = 1'b1;
        req_addr  = 32'h0000_7000;
        req_tid   = 2'd3;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_req_ready", req_ready, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_rd_en", mem_rd_en, 1'b0);
        check("mrst_mem_addr", mem_addr, 32'h0);
        check("mrst_rsp_valid", rsp_valid, 1'b0);
        check("mrst_rsp_line", rsp_line, 128'h0);
        check("mrst_rsp_tid", rsp_tid, 2'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_post_ready", req_ready, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw = saw | rsp_valid | mem_rd_en | busy;
        end
        check("mrst_abandoned", saw, 1'b0);

        // Top-of-address-space fill: arithmetic stays within the line.
        run_to_resp(32'hFFFF_FFF4, 2'd1, 32'hFFFF_FFF0, -1, 2'd0,
                    128'h3F21FFFC_3F21FFF8_3F21FFF4_3F21FFF0);
        finish_resp();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
